// File: rtl/hazard_control_unit_pkg.sv
// ============================================================================
// Module : hazard_control_unit_pkg
// Brief  : Shared state encodings, defaults and helpers for the hazard unit.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package hazard_control_unit_pkg;

  localparam int c_REG_W_DEFAULT = 5;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_STALL  = 2'd1,
    ST_SQUASH = 2'd2,
    ST_UNUSED = 2'd3
  } hcu_state_e;

  // Any nonzero MemRead code denotes a load of some width.
  function automatic logic is_load(input logic [1:0] mem_read);
    return (mem_read != 2'b00);
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_control_unit_sat_counter.sv
// ============================================================================
// Module : sat_counter
// Brief  : Up-counter that sticks at all-ones instead of wrapping.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] c_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_MAX = '1;

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_count <= '0;
    end else if (inc && (r_count != c_MAX)) begin
      r_count <= r_count + c_ONE;
    end
  end

  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/hazard_control_unit.sv
// ============================================================================
// Module : hazard_control_unit
// Brief  : Stall/flush/bubble control for IF, IF/ID and ID/EX with perf counters.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module hazard_control_unit
  import hazard_control_unit_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int REG_W = c_REG_W_DEFAULT
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [REG_W-1:0] ID_Rs,
  input  logic [REG_W-1:0] ID_Rt,
  input  logic             ID_UsesRs,
  input  logic             ID_UsesRt,
  input  logic             ID_Jump,
  input  logic             ID_JumpReturn,
  input  logic [1:0]       EX_MemRead,
  input  logic             EX_RegWrite,
  input  logic [REG_W-1:0] EX_WriteReg,
  input  logic [1:0]       MEM_MemRead,
  input  logic [REG_W-1:0] MEM_WriteReg,
  input  logic             EX_BranchTaken,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Signal,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount,
  output logic [1:0]       State
);

  hcu_state_e r_state;
  hcu_state_e w_next_state;

  logic w_ex_dest_valid;
  logic w_mem_dest_valid;
  logic w_lu;
  logic w_jrx;
  logic w_jrm;
  logic w_hazard;

  // Register 0 is hardwired, so a zero destination can never be a producer.
  assign w_ex_dest_valid  = (EX_WriteReg  != '0);
  assign w_mem_dest_valid = (MEM_WriteReg != '0);

  assign w_lu  = is_load(EX_MemRead) && w_ex_dest_valid &&
                 ((ID_UsesRs && (ID_Rs == EX_WriteReg)) ||
                  (ID_UsesRt && (ID_Rt == EX_WriteReg)));

  // jr resolves its target in ID, so it needs rs from EX and even from a MEM-stage load.
  assign w_jrx = ID_JumpReturn && EX_RegWrite && w_ex_dest_valid &&
                 (ID_Rs == EX_WriteReg);
  assign w_jrm = ID_JumpReturn && is_load(MEM_MemRead) && w_mem_dest_valid &&
                 (ID_Rs == MEM_WriteReg);

  assign w_hazard = w_lu || w_jrx || w_jrm;

  always_comb begin
    PCWrite      = 1'b1;
    IF_ID_Write  = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Signal = 1'b0;
    w_next_state = ST_RUN;

    if (!Reset) begin
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      IF_ID_Flush  = 1'b1;
      ID_EX_Signal = 1'b1;
      w_next_state = ST_RUN;
    end else if (EX_BranchTaken) begin
      IF_ID_Flush  = 1'b1;
      ID_EX_Signal = 1'b1;
      w_next_state = ST_SQUASH;
    end else if (r_state == ST_SQUASH) begin
      // ID holds the nop loaded by the previous flush; its fields are meaningless.
      w_next_state = ST_RUN;
    end else if (w_hazard) begin
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Signal = 1'b1;
      w_next_state = ST_STALL;
    end else if (ID_Jump || ID_JumpReturn) begin
      IF_ID_Flush  = 1'b1;
      w_next_state = ST_SQUASH;
    end else begin
      w_next_state = ST_RUN;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_next_state;
    end
  end

  assign State = r_state;

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .Clk   (Clk),
    .Reset (Reset),
    .inc   (~PCWrite),
    .count (StallCount)
  );

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_flush_cnt (
    .Clk   (Clk),
    .Reset (Reset),
    .inc   (IF_ID_Flush),
    .count (FlushCount)
  );

endmodule

`default_nettype wire

// File: tb/tb_hazard_control_unit.sv
// ============================================================================
// Module : tb_hazard_control_unit
// Brief  : Directed self-checking bench for hazard_control_unit (CNT_W=4).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_hazard_control_unit;

  localparam int CNT_W = 4;
  localparam int REG_W = 5;

  logic             Clk;
  logic             Reset;
  logic [REG_W-1:0] ID_Rs;
  logic [REG_W-1:0] ID_Rt;
  logic             ID_UsesRs;
  logic             ID_UsesRt;
  logic             ID_Jump;
  logic             ID_JumpReturn;
  logic [1:0]       EX_MemRead;
  logic             EX_RegWrite;
  logic [REG_W-1:0] EX_WriteReg;
  logic [1:0]       MEM_MemRead;
  logic [REG_W-1:0] MEM_WriteReg;
  logic             EX_BranchTaken;
  logic             PCWrite;
  logic             IF_ID_Write;
  logic             IF_ID_Flush;
  logic             ID_EX_Signal;
  logic [CNT_W-1:0] StallCount;
  logic [CNT_W-1:0] FlushCount;
  logic [1:0]       State;

  int errors = 0;
  int checks = 0;

  hazard_control_unit #(
    .CNT_W (CNT_W),
    .REG_W (REG_W)
  ) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .ID_Rs          (ID_Rs),
    .ID_Rt          (ID_Rt),
    .ID_UsesRs      (ID_UsesRs),
    .ID_UsesRt      (ID_UsesRt),
    .ID_Jump        (ID_Jump),
    .ID_JumpReturn  (ID_JumpReturn),
    .EX_MemRead     (EX_MemRead),
    .EX_RegWrite    (EX_RegWrite),
    .EX_WriteReg    (EX_WriteReg),
    .MEM_MemRead    (MEM_MemRead),
    .MEM_WriteReg   (MEM_WriteReg),
    .EX_BranchTaken (EX_BranchTaken),
    .PCWrite        (PCWrite),
    .IF_ID_Write    (IF_ID_Write),
    .IF_ID_Flush    (IF_ID_Flush),
    .ID_EX_Signal   (ID_EX_Signal),
    .StallCount     (StallCount),
    .FlushCount     (FlushCount),
    .State          (State)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Signal}
  task automatic check_ctrl(input string tag, input logic [3:0] exp);
    check_value(tag, 32'({PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Signal}), 32'(exp));
  endtask

  task automatic clear_inputs();
    ID_Rs          = '0;
    ID_Rt          = '0;
    ID_UsesRs      = 1'b0;
    ID_UsesRt      = 1'b0;
    ID_Jump        = 1'b0;
    ID_JumpReturn  = 1'b0;
    EX_MemRead     = 2'b00;
    EX_RegWrite    = 1'b0;
    EX_WriteReg    = '0;
    MEM_MemRead    = 2'b00;
    MEM_WriteReg   = '0;
    EX_BranchTaken = 1'b0;
  endtask

  // Land 1 time unit after a rising edge; inputs set here settle before the #1 checks.
  task automatic next_cycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    Reset = 1'b0;
    next_cycle();
    Reset = 1'b1;
    #1;
  endtask

  task automatic set_load_use(input logic [REG_W-1:0] r);
    EX_MemRead  = 2'b01;
    EX_RegWrite = 1'b1;
    EX_WriteReg = r;
    ID_Rs       = r;
    ID_UsesRs   = 1'b1;
  endtask

  initial begin
    clear_inputs();
    Reset = 1'b0;

    // Reset held with random inputs: forced stall/flush/bubble, counters pinned at 0.
    for (int i = 0; i < 4; i++) begin
      ID_Rs          = 5'($urandom);
      ID_Rt          = 5'($urandom);
      ID_UsesRs      = 1'($urandom);
      ID_UsesRt      = 1'($urandom);
      ID_Jump        = 1'($urandom);
      ID_JumpReturn  = 1'($urandom);
      EX_MemRead     = 2'($urandom);
      EX_RegWrite    = 1'($urandom);
      EX_WriteReg    = 5'($urandom);
      MEM_MemRead    = 2'($urandom);
      MEM_WriteReg   = 5'($urandom);
      EX_BranchTaken = 1'($urandom);
      next_cycle();
      #1;
      check_ctrl("rst_ctrl", 4'b0011);
      check_value("rst_stall_cnt", 32'(StallCount), 32'd0);
      check_value("rst_flush_cnt", 32'(FlushCount), 32'd0);
      check_value("rst_state", 32'(State), 32'd0);
    end

    clear_inputs();
    Reset = 1'b1;
    #1;
    check_ctrl("rel_ctrl", 4'b1100);
    check_value("rel_state", 32'(State), 32'd0);

    // Load-use on rs=8: one stall cycle.
    next_cycle();
    set_load_use(5'd8);
    #1;
    check_ctrl("lu_ctrl", 4'b0001);
    next_cycle();
    check_value("lu_state", 32'(State), 32'd1);
    check_value("lu_stall_cnt", 32'(StallCount), 32'd1);
    clear_inputs();
    #1;
    check_ctrl("lu_clear_ctrl", 4'b1100);

    // Load to $0 matching ID rs=$0 must not stall.
    EX_MemRead  = 2'b01;
    EX_WriteReg = 5'd0;
    ID_Rs       = 5'd0;
    ID_UsesRs   = 1'b1;
    #1;
    check_ctrl("lu_r0_ctrl", 4'b1100);
    next_cycle();
    check_value("lu_r0_state", 32'(State), 32'd0);
    check_value("lu_r0_stall_cnt", 32'(StallCount), 32'd1);

    // Load-use through rt only.
    clear_inputs();
    EX_MemRead  = 2'b10;
    EX_WriteReg = 5'd12;
    ID_Rt       = 5'd12;
    ID_UsesRt   = 1'b1;
    #1;
    check_ctrl("lu_rt_ctrl", 4'b0001);
    ID_UsesRt = 1'b0;
    #1;
    check_ctrl("lu_rt_unused_ctrl", 4'b1100);

    // jr $31 behind a load: two stall cycles, then the jump flushes.
    do_reset();
    ID_JumpReturn = 1'b1;
    ID_Rs         = 5'd31;
    ID_UsesRs     = 1'b1;
    EX_MemRead    = 2'b01;
    EX_RegWrite   = 1'b1;
    EX_WriteReg   = 5'd31;
    #1;
    check_ctrl("jrl_c1_ctrl", 4'b0001);
    next_cycle();
    EX_MemRead   = 2'b00;
    EX_RegWrite  = 1'b0;
    EX_WriteReg  = 5'd0;
    MEM_MemRead  = 2'b01;
    MEM_WriteReg = 5'd31;
    #1;
    check_ctrl("jrl_c2_ctrl", 4'b0001);
    check_value("jrl_c2_state", 32'(State), 32'd1);
    next_cycle();
    MEM_MemRead  = 2'b00;
    MEM_WriteReg = 5'd0;
    #1;
    check_ctrl("jrl_c3_ctrl", 4'b1110);
    next_cycle();
    check_value("jrl_sq_state", 32'(State), 32'd2);
    check_value("jrl_stall_cnt", 32'(StallCount), 32'd2);
    check_value("jrl_flush_cnt", 32'(FlushCount), 32'd1);
    clear_inputs();
    #1;
    check_ctrl("jrl_sq_ctrl", 4'b1100);
    next_cycle();
    check_value("jrl_run_state", 32'(State), 32'd0);

    // jr $5 behind an ALU op: single stall cycle.
    do_reset();
    ID_JumpReturn = 1'b1;
    ID_Rs         = 5'd5;
    ID_UsesRs     = 1'b1;
    EX_RegWrite   = 1'b1;
    EX_WriteReg   = 5'd5;
    #1;
    check_ctrl("jra_c1_ctrl", 4'b0001);
    next_cycle();
    EX_RegWrite  = 1'b0;
    EX_WriteReg  = 5'd0;
    MEM_WriteReg = 5'd5;
    #1;
    check_ctrl("jra_c2_ctrl", 4'b1110);
    next_cycle();
    check_value("jra_stall_cnt", 32'(StallCount), 32'd1);
    check_value("jra_state", 32'(State), 32'd2);

    // Taken branch beats a simultaneous load-use; next cycle hazard is masked.
    do_reset();
    set_load_use(5'd9);
    EX_BranchTaken = 1'b1;
    #1;
    check_ctrl("br_ctrl", 4'b1111);
    next_cycle();
    check_value("br_state", 32'(State), 32'd2);
    EX_BranchTaken = 1'b0;
    #1;
    check_ctrl("br_mask_ctrl", 4'b1100);
    next_cycle();
    check_value("br_run_state", 32'(State), 32'd0);
    check_value("br_stall_cnt", 32'(StallCount), 32'd0);
    check_value("br_flush_cnt", 32'(FlushCount), 32'd1);

    // Back-to-back jumps: only the first flushes.
    do_reset();
    ID_Jump = 1'b1;
    #1;
    check_ctrl("jj_c1_ctrl", 4'b1110);
    next_cycle();
    check_value("jj_c1_state", 32'(State), 32'd2);
    #1;
    check_ctrl("jj_c2_ctrl", 4'b1100);
    next_cycle();
    check_value("jj_c2_state", 32'(State), 32'd0);
    check_value("jj_flush_cnt", 32'(FlushCount), 32'd1);
    clear_inputs();

    // Long stall saturates the 4-bit counter at 15; async reset clears it mid-stall.
    do_reset();
    set_load_use(5'd20);
    for (int i = 0; i < 20; i++) begin
      next_cycle();
      if (i == 14) check_value("sat_at15", 32'(StallCount), 32'd15);
    end
    check_value("sat_stall_cnt", 32'(StallCount), 32'd15);
    check_value("sat_state", 32'(State), 32'd1);
    check_ctrl("sat_ctrl", 4'b0001);
    Reset = 1'b0;
    #1;
    check_value("sat_rst_cnt", 32'(StallCount), 32'd0);
    check_value("sat_rst_state", 32'(State), 32'd0);
    check_ctrl("sat_rst_ctrl", 4'b0011);
    clear_inputs();
    next_cycle();
    Reset = 1'b1;
    #1;
    check_ctrl("sat_rel_ctrl", 4'b1100);
    next_cycle();
    check_value("sat_rel_state", 32'(State), 32'd0);
    check_value("sat_rel_cnt", 32'(StallCount), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
